// File: rtl/xadc_sample_packer.sv
// ---------------------------------------------------------------------------
// xadc_sample_packer
//
// Write-side feeder for the 64-bit-in / 32-bit-out sample FIFO. Each XADC
// conversion result arrives as a 12-bit code plus a channel address. The
// packer tags it into a 16-bit entry {ch[3:0], data[11:0]} and packs four
// entries per 64-bit FIFO word. The first sample goes in [63:48] so the 32-bit
// reader sees samples in chronological order, upper half first.
//
// A partial word can be closed early by flush. Unused slots are then filled
// with PAD_ENTRY. A completed word waits in a single output register until the
// FIFO accepts it. Input is never stalled. If a word completes while the
// output register is still occupied and cannot drain, the new word is dropped
// and counted.
//
// Optional feature (macro PACK_TIMEOUT_EN): an idle counter auto-flushes a
// partial word after TIMEOUT_CYC cycles without a new sample. When the macro
// is not defined, a partial word waits until more samples or a flush arrive.
//
// Parameters:
//   PAD_ENTRY    filler entry used to complete a partial word
//   TIMEOUT_CYC  idle cycles before auto-flush (PACK_TIMEOUT_EN only), 2..65535
//   OVF_W        width of the saturating drop counter
//
// Ports:
//   clk         FIFO write clock; all logic runs on its rising edge
//   rst_n       asynchronous active-low reset
//   smp_valid   one-cycle strobe qualifying smp_data / smp_ch
//   smp_data    12-bit XADC conversion code
//   smp_ch      XADC channel address; only bits [3:0] are stored
//   flush       one-cycle strobe: pad and emit the current partial word
//   ovf_clr     clears ovf_cnt and ovf_flag (wins over a same-cycle drop)
//   fifo_full   FIFO full flag
//   fifo_din    packed word to the FIFO, stable while fifo_wr_en is high
//   fifo_wr_en  FIFO write strobe
//   ovf_cnt     saturating count of dropped words
//   ovf_flag    sticky flag: at least one word was dropped
// ---------------------------------------------------------------------------
module xadc_sample_packer #(
  parameter logic [15:0] PAD_ENTRY   = 16'hFFFF,
  parameter int          TIMEOUT_CYC = 1024,
  parameter int          OVF_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             smp_valid,
  input  logic [11:0]      smp_data,
  input  logic [4:0]       smp_ch,
  input  logic             flush,
  input  logic             ovf_clr,
  input  logic             fifo_full,
  output logic [63:0]      fifo_din,
  output logic             fifo_wr_en,
  output logic [OVF_W-1:0] ovf_cnt,
  output logic             ovf_flag
);

  // The slot count doubles as the packing state: it names the slot that the
  // next accepted sample will occupy.
  typedef enum logic [1:0] {
    SLOT0 = 2'd0,
    SLOT1 = 2'd1,
    SLOT2 = 2'd2,
    SLOT3 = 2'd3
  } slot_e;

  slot_e       slot_q;
  slot_e       slot_d;
  logic [63:0] pack_q;
  logic [63:0] pack_d;
  logic [63:0] pack_ins;
  logic [63:0] word;
  logic [63:0] dout_q;
  logic [2:0]  fill;
  logic [15:0] entry;
  logic        eff_flush;
  logic        tmo_flush;
  logic        complete;
  logic        out_valid_q;
  logic        drain;
  logic        drop;

  // Channel bit 4 is not part of the stored entry.
  logic unused_ch_msb;
  assign unused_ch_msb = smp_ch[4];

  assign entry     = {smp_ch[3:0], smp_data};
  assign eff_flush = flush | tmo_flush;

  // The word drains whenever one is held and the FIFO has room.
  assign drain      = out_valid_q & ~fifo_full;
  assign fifo_wr_en = drain;
  assign fifo_din   = dout_q;

  // A completed word is lost only when the output register is busy and does
  // not drain in the same cycle.
  assign drop = complete & out_valid_q & ~drain;

`ifdef PACK_TIMEOUT_EN
  // The flush fires in the cycle the idle count would reach TIMEOUT_CYC. The
  // last sample therefore lands in the FIFO TIMEOUT_CYC+1 cycles later.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] idle_q;

  // Request an internal flush when a partial word has been idle long enough.
  always_comb begin
    tmo_flush = (slot_q != SLOT0) && !smp_valid && (idle_q == TMO_LAST);
  end

  // Idle counter: it only runs while a partial word is pending and no sample
  // arrives. It restarts on a sample, on an empty packer and after firing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
    end else if (smp_valid || (slot_q == SLOT0) || tmo_flush) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + 16'd1;
    end
  end
`else
  assign tmo_flush = 1'b0;

  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  // Packing state register: slot count and the partially assembled word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= SLOT0;
      pack_q <= '0;
    end else begin
      slot_q <= slot_d;
      pack_q <= pack_d;
    end
  end

  // Next-state logic. The incoming sample is inserted first, so a flush in
  // the same cycle closes a word that already contains that sample. When the
  // sample is the fourth one, the word is simply full and nothing is padded.
  always_comb begin
    pack_ins = pack_q;
    word     = '0;
    fill     = '0;
    complete = 1'b0;
    pack_d   = pack_q;
    slot_d   = slot_q;

    if (smp_valid) begin
      case (slot_q)
        SLOT0:   pack_ins[63:48] = entry;
        SLOT1:   pack_ins[47:32] = entry;
        SLOT2:   pack_ins[31:16] = entry;
        default: pack_ins[15:0]  = entry;
      endcase
    end

    fill     = {1'b0, slot_q} + {2'b00, smp_valid};
    complete = (fill == 3'd4) || (eff_flush && (fill != 3'd0));

    word = pack_ins;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) >= fill) begin
        word[63-16*k -: 16] = PAD_ENTRY;
      end
    end

    if (complete) begin
      pack_d = '0;
      slot_d = SLOT0;
    end else begin
      pack_d = pack_ins;
      slot_d = slot_e'(fill[1:0]);
    end
  end

  // Output register. A new word may load in the same cycle that the held
  // word drains. Otherwise, a busy register keeps its word and the new one
  // is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
    end else if (complete && !drop) begin
      out_valid_q <= 1'b1;
      dout_q      <= word;
    end else if (drain) begin
      out_valid_q <= 1'b0;
    end
  end

  // Drop accounting. A clear wins over a same-cycle drop. The counter sticks
  // at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt  <= '0;
      ovf_flag <= 1'b0;
    end else if (ovf_clr) begin
      ovf_cnt  <= '0;
      ovf_flag <= 1'b0;
    end else if (drop) begin
      ovf_flag <= 1'b1;
      if (ovf_cnt != {OVF_W{1'b1}}) begin
        ovf_cnt <= ovf_cnt + {{(OVF_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule
